mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 33 +++
 rtl/mem_access_unit.sv | 141 ++++++++++++++
 tb/tb_mem_access_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Request/response and SRAM bus bundle for mem_access_unit.
// slave: the access unit; master: sequence controller plus SRAM.
interface mem_access_unit_if;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned SW = 30;

  logic          MEM_OE;
  logic          MEM_WS;
  logic [1:0]    ACC_SIZE;
  logic          ACC_UNSIGNED;
  logic [AW-1:0] ADDR;
  logic [DW-1:0] WR_DATA;
  logic [DW-1:0] RD_DATA;
  logic          MEM_BUSY;
  logic          MEM_DONE;
  logic          ADDR_ERR;
  logic [SW-1:0] SRAM_ADDR;
  logic          SRAM_CE;
  logic          SRAM_WE;
  logic [DW-1:0] SRAM_WDATA;
  logic [DW-1:0] SRAM_RDATA;

  modport slave (
    input  MEM_OE, MEM_WS, ACC_SIZE, ACC_UNSIGNED, ADDR, WR_DATA, SRAM_RDATA,
    output RD_DATA, MEM_BUSY, MEM_DONE, ADDR_ERR, SRAM_ADDR, SRAM_CE, SRAM_WE, SRAM_WDATA
  );

  modport master (
    output MEM_OE, MEM_WS, ACC_SIZE, ACC_UNSIGNED, ADDR, WR_DATA, SRAM_RDATA,
    input  RD_DATA, MEM_BUSY, MEM_DONE, ADDR_ERR, SRAM_ADDR, SRAM_CE, SRAM_WE, SRAM_WDATA
  );
endinterface

// File: rtl/mem_access_unit.sv
// Big-endian load/store unit over a single-port synchronous SRAM; sub-word stores use read-modify-write.
// Define MISALIGN_EXC_EN to raise ADDR_ERR on misaligned accesses instead of masking the low address bits.
module mem_access_unit (
  input  logic               CLK,
  input  logic               RST,
  mem_access_unit_if.slave   bus
);
  localparam int unsigned DW = 32;

  typedef enum logic [2:0] {IDLE, READ, RMW_RD, RMW_WR, WRITE, DONE} state_t;

  state_t        state_q, state_d;
  logic          load_c;
  logic          req_c, wr_req_c, req_word_c, req_half_c, bad_c;
  logic [DW-1:0] addr_lat_c;

  logic [DW-1:0] addr_q, wr_q, rd_q;
  logic [1:0]    size_q;
  logic          uns_q, is_rd_q, err_q;
  logic          busy_q, done_q, ce_q, we_q;

  logic [4:0]    sh_c;
  logic [DW-1:0] lane_c, ld_c, mask_c, merge_c, wdata_c;

  assign req_c      = bus.MEM_OE | bus.MEM_WS;
  assign wr_req_c   = bus.MEM_WS;
  assign req_word_c = (bus.ACC_SIZE == 2'b00) || (bus.ACC_SIZE == 2'b11);
  assign req_half_c = (bus.ACC_SIZE == 2'b01);

`ifdef MISALIGN_EXC_EN
  assign bad_c      = (req_word_c && (bus.ADDR[1:0] != 2'b00)) || (req_half_c && bus.ADDR[0]);
  assign addr_lat_c = bus.ADDR;
`else
  assign bad_c = 1'b0;
  // Misaligned low bits are silently dropped so the access lands on its natural boundary
  always_comb begin
    addr_lat_c = bus.ADDR;
    if (req_word_c)      addr_lat_c[1:0] = 2'b00;
    else if (req_half_c) addr_lat_c[0]   = 1'b0;
  end
`endif

  // Next-state decode
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_c) begin
          load_c = 1'b1;
          if (bad_c)         state_d = DONE;
          else if (!wr_req_c) state_d = READ;
          else if (req_word_c) state_d = WRITE;
          else               state_d = RMW_RD;
        end
      end
      READ:    state_d = DONE;
      WRITE:   state_d = DONE;
      RMW_RD:  state_d = RMW_WR;
      RMW_WR:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Lane select / sign extension for loads and lane merge for sub-word stores
  always_comb begin
    case (size_q)
      2'b10:   sh_c = {~addr_q[1:0], 3'b000};
      2'b01:   sh_c = {~addr_q[1], 4'b0000};
      default: sh_c = 5'd0;
    endcase
    lane_c = bus.SRAM_RDATA >> sh_c;
    case (size_q)
      2'b10:   ld_c = uns_q ? {24'd0, lane_c[7:0]}  : {{24{lane_c[7]}},  lane_c[7:0]};
      2'b01:   ld_c = uns_q ? {16'd0, lane_c[15:0]} : {{16{lane_c[15]}}, lane_c[15:0]};
      default: ld_c = lane_c;
    endcase
    mask_c  = (size_q == 2'b10) ? 32'h0000_00FF : 32'h0000_FFFF;
    merge_c = (bus.SRAM_RDATA & ~(mask_c << sh_c)) | ((wr_q & mask_c) << sh_c);
    wdata_c = '0;
    if (state_q == WRITE)       wdata_c = wr_q;
    else if (state_q == RMW_WR) wdata_c = merge_c;
  end

  // Request latch and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      addr_q  <= '0;
      wr_q    <= '0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      is_rd_q <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ce_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      if (load_c) begin
        addr_q  <= addr_lat_c;
        wr_q    <= bus.WR_DATA;
        size_q  <= bus.ACC_SIZE;
        uns_q   <= bus.ACC_UNSIGNED;
        is_rd_q <= ~wr_req_c;
        err_q   <= bad_c;
      end
      if ((state_q == DONE) && is_rd_q && !err_q) rd_q <= ld_c;
      busy_q <= (state_d != IDLE);
      done_q <= (state_q == DONE);
      ce_q   <= (state_d == READ) || (state_d == WRITE) || (state_d == RMW_RD) || (state_d == RMW_WR);
      we_q   <= (state_d == WRITE) || (state_d == RMW_WR);
    end
  end

`ifdef MISALIGN_EXC_EN
  logic aerr_q;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) aerr_q <= 1'b0;
    else      aerr_q <= (state_q == DONE) && err_q;
  end
  assign bus.ADDR_ERR = aerr_q;
`else
  assign bus.ADDR_ERR = 1'b0;
`endif

  // Merged RMW word depends on the SRAM word returned in the RMW_WR cycle itself
  assign bus.SRAM_WDATA = wdata_c;
  assign bus.SRAM_ADDR  = addr_q[31:2];
  assign bus.SRAM_CE    = ce_q;
  assign bus.SRAM_WE    = we_q;
  assign bus.RD_DATA    = rd_q;
  assign bus.MEM_BUSY   = busy_q;
  assign bus.MEM_DONE   = done_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table plus scoreboard queue, behavioural SRAM.
module tb_mem_access_unit;
`ifdef MISALIGN_EXC_EN
  localparam bit EXC = 1'b1;
`else
  localparam bit EXC = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  mem_access_unit_if bus ();
  mem_access_unit dut (.CLK(CLK), .RST(RST), .bus(bus));

  typedef struct {
    logic        oe, ws;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, wdata, init, exp_rd, exp_mem;
    int          lat, ce, we;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rd, mem;
    int          lat, ce, we;
    logic        err;
    logic [3:0]  idx;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [16];
  logic        bd_we = 1'b0;
  logic [3:0]  bd_idx = 4'd0;
  logic [31:0] bd_data = 32'd0;
  int          ce_cnt = 0;
  int          we_cnt = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_rd = 32'd0;
  vec_t        vt[$];

  // Synchronous SRAM model: read data appears the cycle after a CE=1, WE=0 cycle
  always @(posedge CLK) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (bus.SRAM_CE && bus.SRAM_WE) mem[bus.SRAM_ADDR[3:0]] <= bus.SRAM_WDATA;
    if (bus.SRAM_CE && !bus.SRAM_WE) bus.SRAM_RDATA <= mem[bus.SRAM_ADDR[3:0]];
    if (bus.SRAM_CE) ce_cnt <= ce_cnt + 1;
    if (bus.SRAM_CE && bus.SRAM_WE) we_cnt <= we_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    bd_idx = a[5:2]; bd_data = d; bd_we = 1'b1;
    @(posedge CLK); #1;
    bd_we = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 8) begin
      @(posedge CLK); #1;
      lat++;
      if (bus.MEM_DONE) break;
    end
    if (!bus.MEM_DONE) begin
      total++; bad++;
      $display("FAIL done_timeout actual=no_MEM_DONE required=MEM_DONE within 8 cycles");
    end
  endtask

  function automatic vec_t mk(logic oe, logic ws, logic [1:0] size, logic uns,
                              logic [31:0] addr, logic [31:0] wdata, logic [31:0] init,
                              logic [31:0] exp_rd, logic [31:0] exp_mem,
                              int lat, int ce, int we, logic err);
    vec_t v;
    v.oe = oe; v.ws = ws; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.init = init; v.exp_rd = exp_rd; v.exp_mem = exp_mem; v.lat = lat; v.ce = ce; v.we = we; v.err = err;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input bit do_preload);
    exp_t e, g;
    int   ce0, we0, lat;
    bit   is_rd;
    if (do_preload) preload(v.addr, v.init);
    is_rd  = v.oe && !v.ws;
    e.rd   = (is_rd && !v.err) ? v.exp_rd : last_rd;
    if (is_rd && !v.err) last_rd = v.exp_rd;
    e.mem  = v.exp_mem; e.lat = v.lat; e.ce = v.ce; e.we = v.we; e.err = v.err;
    e.idx  = v.addr[5:2];
    exp_q.push_back(e);
    ce0 = ce_cnt; we0 = we_cnt;
    bus.MEM_OE = v.oe; bus.MEM_WS = v.ws; bus.ACC_SIZE = v.size;
    bus.ACC_UNSIGNED = v.uns; bus.ADDR = v.addr; bus.WR_DATA = v.wdata;
    @(posedge CLK); #1;
    bus.MEM_OE = 1'b0; bus.MEM_WS = 1'b0;
    chk("busy_after_accept", 32'(bus.MEM_BUSY), 32'd1);
    wait_done(lat);
    g = exp_q.pop_front();
    chk("latency", 32'(lat), 32'(g.lat));
    chk("rd_data", bus.RD_DATA, g.rd);
    chk("addr_err", 32'(bus.ADDR_ERR), 32'(g.err));
    chk("ce_pulses", 32'(ce_cnt - ce0), 32'(g.ce));
    chk("we_pulses", 32'(we_cnt - we0), 32'(g.we));
    chk("sram_word", mem[g.idx], g.mem);
    @(posedge CLK); #1;
    chk("done_one_cycle", {30'd0, bus.MEM_DONE, bus.ADDR_ERR}, 32'd0);
  endtask

  initial begin
    int lat, ce0, we0;
    bus.MEM_OE = 1'b0; bus.MEM_WS = 1'b0; bus.ACC_SIZE = 2'b00; bus.ACC_UNSIGNED = 1'b0;
    bus.ADDR = 32'd0; bus.WR_DATA = 32'd0;

    // Reset values
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_rd_data", bus.RD_DATA, 32'd0);
    chk("reset_ctrl", {27'd0, bus.MEM_BUSY, bus.MEM_DONE, bus.ADDR_ERR, bus.SRAM_CE, bus.SRAM_WE}, 32'd0);
    chk("reset_sram_addr", {2'b00, bus.SRAM_ADDR}, 32'd0);
    chk("reset_sram_wdata", bus.SRAM_WDATA, 32'd0);
    @(negedge CLK); RST = 1'b1;

    //        oe ws size  uns addr          wdata         init          exp_rd        exp_mem       lat          ce           we          err
    vt.push_back(mk(1, 0, 2'b00, 0, 32'h8000_0004, 32'h0,        32'h1122_3344, 32'h1122_3344, 32'h1122_3344, 2, 1, 0, 0));
    vt.push_back(mk(1, 0, 2'b10, 0, 32'h8000_0009, 32'h0,        32'hAABB_CCDD, 32'hFFFF_FFBB, 32'hAABB_CCDD, 2, 1, 0, 0));
    vt.push_back(mk(1, 0, 2'b10, 1, 32'h8000_0009, 32'h0,        32'hAABB_CCDD, 32'h0000_00BB, 32'hAABB_CCDD, 2, 1, 0, 0));
    vt.push_back(mk(1, 0, 2'b01, 0, 32'h8000_0008, 32'h0,        32'hAABB_CCDD, 32'hFFFF_AABB, 32'hAABB_CCDD, 2, 1, 0, 0));
    vt.push_back(mk(1, 0, 2'b01, 1, 32'h8000_000A, 32'h0,        32'hAABB_CCDD, 32'h0000_CCDD, 32'hAABB_CCDD, 2, 1, 0, 0));
    vt.push_back(mk(1, 0, 2'b10, 0, 32'h8000_000B, 32'h0,        32'hAABB_CC7D, 32'h0000_007D, 32'hAABB_CC7D, 2, 1, 0, 0));
    vt.push_back(mk(1, 0, 2'b11, 0, 32'h8000_0004, 32'h0,        32'h0102_0304, 32'h0102_0304, 32'h0102_0304, 2, 1, 0, 0));
    vt.push_back(mk(0, 1, 2'b01, 0, 32'h8000_000A, 32'h0000_1234, 32'hAABB_CCDD, 32'h0,       32'hAABB_1234, 3, 2, 1, 0));
    vt.push_back(mk(0, 1, 2'b10, 0, 32'h8000_0008, 32'hFFFF_FF55, 32'hAABB_CCDD, 32'h0,       32'h55BB_CCDD, 3, 2, 1, 0));
    vt.push_back(mk(0, 1, 2'b10, 0, 32'h8000_000B, 32'h0000_00EE, 32'hAABB_CCDD, 32'h0,       32'hAABB_CCEE, 3, 2, 1, 0));
    vt.push_back(mk(1, 1, 2'b00, 0, 32'h8000_000C, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0,       32'hDEAD_BEEF, 2, 1, 1, 0));
    vt.push_back(mk(1, 0, 2'b00, 0, 32'h8000_0006, 32'h0,        32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D, EXC ? 1 : 2, EXC ? 0 : 1, 0, EXC));
    vt.push_back(mk(1, 0, 2'b01, 0, 32'h8000_0005, 32'h0,        32'h8001_ABCD, 32'hFFFF_8001, 32'h8001_ABCD, EXC ? 1 : 2, EXC ? 0 : 1, 0, EXC));
    vt.push_back(mk(0, 1, 2'b00, 0, 32'h8000_000F, 32'h0BAD_F00D, 32'h1111_1111, 32'h0,
                    EXC ? 32'h1111_1111 : 32'h0BAD_F00D, EXC ? 1 : 2, EXC ? 0 : 1, EXC ? 0 : 1, EXC));
    vt.push_back(mk(0, 1, 2'b01, 0, 32'h8000_0009, 32'h0000_BEEF, 32'hAABB_CCDD, 32'h0,
                    EXC ? 32'hAABB_CCDD : 32'hBEEF_CCDD, EXC ? 1 : 3, EXC ? 0 : 2, EXC ? 0 : 1, EXC));

    for (int i = 0; i < vt.size(); i++) run_vec(vt[i], 1'b1);

    // Request raised while busy must be dropped
    preload(32'h8000_0004, 32'h1357_9BDF);
    preload(32'h8000_0010, 32'h0000_0000);
    ce0 = ce_cnt;
    bus.MEM_OE = 1'b1; bus.MEM_WS = 1'b0; bus.ACC_SIZE = 2'b00; bus.ADDR = 32'h8000_0004;
    @(posedge CLK); #1;
    bus.MEM_OE = 1'b0; bus.MEM_WS = 1'b1; bus.ADDR = 32'h8000_0010; bus.WR_DATA = 32'hFFFF_FFFF;
    @(posedge CLK); #1;
    bus.MEM_WS = 1'b0;
    wait_done(lat);
    last_rd = 32'h1357_9BDF;
    chk("busy_ignore_rd", bus.RD_DATA, 32'h1357_9BDF);
    repeat (3) @(posedge CLK);
    #1;
    chk("busy_ignore_idle", 32'(bus.MEM_BUSY), 32'd0);
    chk("busy_ignore_mem", mem[4], 32'h0000_0000);
    chk("busy_ignore_ce", 32'(ce_cnt - ce0), 32'd1);

    // Reset during RMW_RD aborts the store
    preload(32'h8000_0008, 32'hAABB_CCDD);
    we0 = we_cnt;
    bus.MEM_WS = 1'b1; bus.ACC_SIZE = 2'b01; bus.ADDR = 32'h8000_000A; bus.WR_DATA = 32'h0000_1234;
    @(posedge CLK); #1;
    bus.MEM_WS = 1'b0;
    chk("rmw_rd_cycle", {30'd0, bus.SRAM_CE, bus.SRAM_WE}, 32'd2);
    #2 RST = 1'b0;
    #1;
    chk("rst_rd_data", bus.RD_DATA, 32'd0);
    chk("rst_ctrl", {27'd0, bus.MEM_BUSY, bus.MEM_DONE, bus.ADDR_ERR, bus.SRAM_CE, bus.SRAM_WE}, 32'd0);
    chk("rst_sram_addr", {2'b00, bus.SRAM_ADDR}, 32'd0);
    chk("rst_sram_wdata", bus.SRAM_WDATA, 32'd0);
    last_rd = 32'd0;
    preload(32'h8000_000C, 32'h5A5A_A5A5);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_no_we", 32'(we_cnt - we0), 32'd0);
    chk("rst_mem_kept", mem[2], 32'hAABB_CCDD);
    @(negedge CLK); RST = 1'b1;
    run_vec(mk(1, 0, 2'b00, 0, 32'h8000_000C, 32'h0, 32'h5A5A_A5A5, 32'h5A5A_A5A5, 32'h5A5A_A5A5, 2, 1, 0, 0), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
